coproc_sequencer: RTL and testbench
===================================

COPROC_SEQUENCER -- requirements
Module: coproc_sequencer

Interface
REQ-001 SHALL have parameter DET_TIMEOUT, default 255, max cycles waited for determinant completion (1..1023).
REQ-002 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have command inputs: cmd_valid in 1; cmd_op in 3 (opcode); cmd_matrix_a in 200; cmd_matrix_b in 200; cmd_scalar in 8 (signed).
REQ-005 SHALL have cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have coprocessor-side outputs: cp_op_code out 3; cp_matrix_a out 200; cp_matrix_b out 200; cp_scalar out 8; cp_start out 1 (determinant start pulse).
REQ-007 SHALL have coprocessor-side inputs: cp_result in 200; cp_overflow in 1; cp_det_done in 1.
REQ-008 SHALL have response outputs: rsp_valid out 1; rsp_result out 200; rsp_overflow out 1; rsp_op out 3; rsp_err out 1 (illegal opcode); rsp_timeout out 1.
REQ-009 SHALL have rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-010 SHALL have busy  out  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, EXEC, DSTART, DWAIT, RESP.
REQ-012 SHALL assert cmd_ready only in IDLE, so at most one command is in flight.
REQ-013 On accept in IDLE, SHALL register cmd_op/matrices/scalar into cp_* outputs and hold them stable until return to IDLE.
REQ-014 Opcodes 000-100 (add, sub, transpose, opposite, scalar mult): IDLE->EXEC; in EXEC capture cp_result/cp_overflow at the closing edge; EXEC->RESP.
REQ-015 Combinational-op latency: rsp_valid high exactly 2 cycles after the accepting edge.
REQ-016 Opcode 101 (determinant): IDLE->DSTART; cp_start high for exactly one cycle in DSTART; DSTART->DWAIT.
REQ-017 In DWAIT, SHALL capture cp_result (rsp_overflow=0) on the first edge with cp_det_done=1, then go to RESP.
REQ-018 In DWAIT, SHALL count cycles from 1; if count reaches DET_TIMEOUT with cp_det_done still 0, go to RESP with rsp_result=0, rsp_timeout=1.
REQ-019 cp_det_done in the same cycle as timeout expiry SHALL win: result captured, rsp_timeout=0.
REQ-020 Opcodes 110/111: IDLE->RESP directly; rsp_result=0, rsp_overflow=0, rsp_err=1; no cp_start; rsp_valid 1 cycle after accept.
REQ-021 In RESP, rsp_valid=1 and all rsp_* held stable until rsp_ready=1; that edge returns to IDLE.
REQ-022 rsp_op SHALL echo the accepted opcode; rsp_err and rsp_timeout are mutually exclusive.
REQ-023 cp_det_done outside DWAIT SHALL be ignored.
REQ-024 One idle cycle between responses is mandatory (rsp handshake -> IDLE -> next accept).

Reset
REQ-025 On rst=1 at a clock edge, SHALL enter IDLE from any state, including mid DWAIT or RESP; pending response discarded.
REQ-026 Reset values: cmd_ready=0 during rst, 1 first cycle after; cp_start=0, rsp_valid=0, busy=0, rsp_err=0, rsp_timeout=0, rsp_overflow=0, all data/opcode outputs 0, timeout counter 0.

Structure
REQ-027 Package coproc_pkg SHALL hold opcode constants (OP_ADD=000 .. OP_DET=101), state encoding, MATRIX_W=200, ELEM_W=8.
REQ-028 SHALL be a single module with no sub-module; timeout counter inline, 10 bits wide.
REQ-029 SHALL contain no arithmetic on matrix data; data passes through registers only.

Verification
REQ-030 Add: A all bytes 0x01, B all 0x02, op 000, cp model returns sum -> rsp_valid 2 cycles after accept, rsp_result all bytes 0x03, rsp_overflow=0.
REQ-031 Overflow: A byte0=0x7F, B byte0=0x01, op 000, model overflow=1 -> rsp_overflow=1, rsp_err=0.
REQ-032 Determinant: A identity, op 101, model asserts cp_det_done 20 cycles after cp_start with result 1 -> single cp_start pulse, rsp_result=1, rsp_timeout=0.
REQ-033 Timeout: DET_TIMEOUT=8, op 101, cp_det_done never -> RESP after 8 DWAIT cycles, rsp_result=0, rsp_timeout=1; done on cycle 8 -> rsp_timeout=0.
REQ-034 Illegal op 110 with rsp_ready low 5 cycles -> rsp_err=1, rsp_valid and outputs stable 5 cycles, cmd_ready=0 throughout, IDLE after handshake.
REQ-035 rst=1 in DWAIT cycle 3 -> next cycle IDLE, busy=0, rsp_valid=0; later cp_det_done pulse produces no response.

Source files
------------

// File: rtl/coproc_sequencer_pkg.sv
// coproc_pkg: opcodes, FSM state encoding and widths shared by the coprocessor sequencer and its bench
package coproc_pkg;
  localparam int MATRIX_W = 200;
  localparam int ELEM_W = 8;
  localparam int OP_W = 3;
  localparam int CNT_W = 10;
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_TRN = 3'b010;
  localparam logic [OP_W-1:0] OP_NEG = 3'b011;
  localparam logic [OP_W-1:0] OP_SMUL = 3'b100;
  localparam logic [OP_W-1:0] OP_DET = 3'b101;
  typedef enum logic [2:0] {IDLE, EXEC, DSTART, DWAIT, RESP} state_t;
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op > OP_DET;
  endfunction
endpackage

// File: rtl/coproc_sequencer_if.sv
// coproc_sequencer_if: command, coprocessor and response bundle; slave = sequencer, master = host/coprocessor side
interface coproc_sequencer_if;
  import coproc_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [MATRIX_W-1:0] cmd_matrix_a;
  logic [MATRIX_W-1:0] cmd_matrix_b;
  logic [ELEM_W-1:0] cmd_scalar;
  logic [OP_W-1:0] cp_op_code;
  logic [MATRIX_W-1:0] cp_matrix_a;
  logic [MATRIX_W-1:0] cp_matrix_b;
  logic [ELEM_W-1:0] cp_scalar;
  logic cp_start;
  logic [MATRIX_W-1:0] cp_result;
  logic cp_overflow;
  logic cp_det_done;
  logic rsp_valid;
  logic rsp_ready;
  logic [MATRIX_W-1:0] rsp_result;
  logic rsp_overflow;
  logic [OP_W-1:0] rsp_op;
  logic rsp_err;
  logic rsp_timeout;
  modport slave (
    input cmd_valid, cmd_op, cmd_matrix_a, cmd_matrix_b, cmd_scalar,
    input cp_result, cp_overflow, cp_det_done, rsp_ready,
    output cmd_ready, cp_op_code, cp_matrix_a, cp_matrix_b, cp_scalar, cp_start,
    output rsp_valid, rsp_result, rsp_overflow, rsp_op, rsp_err, rsp_timeout
  );
  modport master (
    output cmd_valid, cmd_op, cmd_matrix_a, cmd_matrix_b, cmd_scalar,
    output cp_result, cp_overflow, cp_det_done, rsp_ready,
    input cmd_ready, cp_op_code, cp_matrix_a, cp_matrix_b, cp_scalar, cp_start,
    input rsp_valid, rsp_result, rsp_overflow, rsp_op, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/coproc_sequencer.sv
// coproc_sequencer: one-command-in-flight sequencer; ports clk, rst, bus (cmd/cp/rsp via coproc_sequencer_if.slave), busy
module coproc_sequencer
  import coproc_pkg::*;
#(
  parameter int DET_TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  coproc_sequencer_if.slave bus,
  output logic busy
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic accept;
  logic expired;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign expired = cnt == CNT_W'(DET_TIMEOUT);
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.cp_start = state == DSTART;
  assign bus.rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !accept ? IDLE : is_illegal(bus.cmd_op) ? RESP : bus.cmd_op == OP_DET ? DSTART : EXEC;
      EXEC: state_n = RESP;
      DSTART: state_n = DWAIT;
      DWAIT: state_n = (bus.cp_det_done || expired) ? RESP : DWAIT;
      RESP: state_n = bus.rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.cp_op_code <= '0;
      bus.cp_matrix_a <= '0;
      bus.cp_matrix_b <= '0;
      bus.cp_scalar <= '0;
      bus.rsp_result <= '0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_op <= '0;
      bus.rsp_err <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && accept) begin
        bus.cp_op_code <= bus.cmd_op;
        bus.cp_matrix_a <= bus.cmd_matrix_a;
        bus.cp_matrix_b <= bus.cmd_matrix_b;
        bus.cp_scalar <= bus.cmd_scalar;
        bus.rsp_op <= bus.cmd_op;
        bus.rsp_result <= '0;
        bus.rsp_overflow <= 1'b0;
        bus.rsp_err <= is_illegal(bus.cmd_op);
        bus.rsp_timeout <= 1'b0;
        cnt <= '0;
      end
      if (state == EXEC) begin
        bus.rsp_result <= bus.cp_result;
        bus.rsp_overflow <= bus.cp_overflow;
      end
      // cnt holds the number of the current DWAIT cycle, so it starts at 1
      if (state == DSTART) cnt <= CNT_W'(1);
      // a done arriving in the expiry cycle takes priority over the timeout
      if (state == DWAIT) begin
        if (bus.cp_det_done) bus.rsp_result <= bus.cp_result;
        else if (expired) bus.rsp_timeout <= 1'b1;
        else cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_coproc_sequencer.sv
// tb_coproc_sequencer: directed self-checking bench; dut0 uses the default timeout, dut8 uses DET_TIMEOUT=8
module tb_coproc_sequencer;
  import coproc_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0;
  logic rsp_ready = 1'b0;
  logic cp_det_done = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [199:0] cmd_a = '0;
  logic [199:0] cmd_b = '0;
  logic [7:0] cmd_s = '0;
  logic [199:0] det_res = '0;
  logic [199:0] cp_result;
  logic cp_overflow;
  logic [200:0] mdl;
  logic busy0, busy1;
  logic [199:0] ident;
  int n_tests = 0;
  int n_fail = 0;
  int starts = 0;
  coproc_sequencer_if b0();
  coproc_sequencer_if b1();
  coproc_sequencer dut0 (.clk(clk), .rst(rst), .bus(b0), .busy(busy0));
  coproc_sequencer #(.DET_TIMEOUT(8)) dut8 (.clk(clk), .rst(rst), .bus(b1), .busy(busy1));
  assign b0.cmd_valid = cmd_valid;
  assign b0.cmd_op = cmd_op;
  assign b0.cmd_matrix_a = cmd_a;
  assign b0.cmd_matrix_b = cmd_b;
  assign b0.cmd_scalar = cmd_s;
  assign b0.cp_result = cp_result;
  assign b0.cp_overflow = cp_overflow;
  assign b0.cp_det_done = cp_det_done;
  assign b0.rsp_ready = rsp_ready;
  assign b1.cmd_valid = cmd_valid;
  assign b1.cmd_op = cmd_op;
  assign b1.cmd_matrix_a = cmd_a;
  assign b1.cmd_matrix_b = cmd_b;
  assign b1.cmd_scalar = cmd_s;
  assign b1.cp_result = cp_result;
  assign b1.cp_overflow = cp_overflow;
  assign b1.cp_det_done = cp_det_done;
  assign b1.rsp_ready = rsp_ready;
  function automatic logic [200:0] cp_model(input logic [2:0] op, input logic [199:0] a, input logic [199:0] b, input logic [7:0] s);
    logic [199:0] r;
    logic ovf;
    int x;
    r = '0;
    ovf = 1'b0;
    for (int i = 0; i < 25; i++) begin
      case (op)
        OP_ADD: x = int'($signed(a[i*8+:8])) + int'($signed(b[i*8+:8]));
        OP_SUB: x = int'($signed(a[i*8+:8])) - int'($signed(b[i*8+:8]));
        OP_TRN: x = int'($signed(a[((i % 5) * 5 + i / 5)*8+:8]));
        OP_NEG: x = -int'($signed(a[i*8+:8]));
        default: x = int'($signed(a[i*8+:8])) * int'($signed(s));
      endcase
      ovf = ovf | (x > 127) | (x < -128);
      r[i*8+:8] = x[7:0];
    end
    return {ovf, r};
  endfunction
  always_comb begin
    mdl = cp_model(b0.cp_op_code, b0.cp_matrix_a, b0.cp_matrix_b, b0.cp_scalar);
    cp_result = (b0.cp_op_code == OP_DET) ? det_res : mdl[199:0];
    cp_overflow = (b0.cp_op_code == OP_DET) ? 1'b0 : mdl[200];
  end
  always @(posedge clk) if (b0.cp_start) starts <= starts + 1;
  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] op, input logic [199:0] a, input logic [199:0] b, input logic [7:0] s);
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_s = s;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
  task automatic comb_op(input string tag, input logic [2:0] op, input logic [199:0] a, input logic [199:0] b,
                         input logic [7:0] s, input logic [199:0] exp, input logic exp_ovf);
    send(op, a, b, s);
    chk({tag, "_lat1"}, {busy0, b0.rsp_valid, b0.cmd_ready, b0.cp_start}, 4'b1000);
    chk({tag, "_cpa"}, b0.cp_matrix_a, a);
    tick();
    chk({tag, "_valid"}, b0.rsp_valid, 1'b1);
    chk({tag, "_res"}, b0.rsp_result, exp);
    chk({tag, "_flags"}, {b0.rsp_overflow, b0.rsp_err, b0.rsp_timeout}, {exp_ovf, 2'b00});
    chk({tag, "_op"}, b0.rsp_op, op);
    handshake();
    chk({tag, "_idle"}, {busy0, b0.rsp_valid, b0.cmd_ready}, 3'b001);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    ident = '0;
    for (int i = 0; i < 25; i += 6) ident[i*8+:8] = 8'h01;
    tick();
    tick();
    chk("rst_ctrl", {b0.cmd_ready, b0.cp_start, b0.rsp_valid, busy0}, 4'b0000);
    chk("rst_flags", {b0.rsp_err, b0.rsp_timeout, b0.rsp_overflow, b0.cp_op_code, b0.rsp_op}, '0);
    chk("rst_data", b0.rsp_result | b0.cp_matrix_a | b0.cp_matrix_b, '0);
    rst = 1'b0;
    tick();
    chk("rst_ready", b0.cmd_ready, 1'b1);
    comb_op("add", OP_ADD, {25{8'h01}}, {25{8'h02}}, 8'h00, {25{8'h03}}, 1'b0);
    comb_op("ovf", OP_ADD, 200'h7f, 200'h01, 8'h00, 200'h80, 1'b1);
    comb_op("sub", OP_SUB, {25{8'h05}}, {25{8'h07}}, 8'h00, {25{8'hfe}}, 1'b0);
    comb_op("smul", OP_SMUL, {25{8'h03}}, '0, 8'hfe, {25{8'hfa}}, 1'b0);
    comb_op("trn", OP_TRN, 200'h11 << 8, '0, 8'h00, 200'h11 << 40, 1'b0);
    // determinant completing 20 cycles after the start pulse
    starts = 0;
    det_res = 200'd1;
    send(OP_DET, ident, '0, 8'h00);
    chk("det_start", b0.cp_start, 1'b1);
    tick();
    chk("det_start_off", {b0.cp_start, busy0}, 2'b01);
    for (int i = 0; i < 19; i++) tick();
    cp_det_done = 1'b1;
    tick();
    cp_det_done = 1'b0;
    chk("det_valid", b0.rsp_valid, 1'b1);
    chk("det_res", b0.rsp_result, 200'd1);
    chk("det_flags", {b0.rsp_timeout, b0.rsp_overflow, b0.rsp_err, b0.rsp_op}, {3'b000, OP_DET});
    chk("det_pulses", 200'(starts), 200'd1);
    chk("det8_timeout", {b1.rsp_valid, b1.rsp_timeout, b1.rsp_result == '0}, 3'b111);
    handshake();
    chk("det_idle", {busy0, busy1}, 2'b00);
    // timeout on dut8 while dut0 keeps waiting
    det_res = 200'h55;
    send(OP_DET, ident, '0, 8'h00);
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("to_cycle8", {b1.rsp_valid, busy1}, 2'b01);
    tick();
    chk("to_valid", b1.rsp_valid, 1'b1);
    chk("to_flags", {b1.rsp_timeout, b1.rsp_err, b1.rsp_overflow}, 3'b100);
    chk("to_res", b1.rsp_result, '0);
    chk("to_dut0_wait", {b0.rsp_valid, busy0}, 2'b01);
    handshake();
    chk("to_idle", {b1.rsp_valid, busy1}, 2'b00);
    cp_det_done = 1'b1;
    tick();
    cp_det_done = 1'b0;
    chk("to_ignore_done", {b1.rsp_valid, busy1}, 2'b00);
    chk("to_dut0_res", b0.rsp_result, 200'h55);
    handshake();
    chk("to_dut0_idle", busy0, 1'b0);
    // done arriving in the expiry cycle beats the timeout
    det_res = 200'h42;
    send(OP_DET, ident, '0, 8'h00);
    tick();
    for (int i = 0; i < 7; i++) tick();
    cp_det_done = 1'b1;
    tick();
    cp_det_done = 1'b0;
    chk("race_valid", b1.rsp_valid, 1'b1);
    chk("race_res", b1.rsp_result, 200'h42);
    chk("race_timeout", b1.rsp_timeout, 1'b0);
    handshake();
    // illegal opcode held for 5 cycles without rsp_ready
    starts = 0;
    send(3'b110, {25{8'haa}}, '0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("ill_valid", {b0.rsp_valid, b0.cmd_ready, b0.cp_start}, 3'b100);
      chk("ill_flags", {b0.rsp_err, b0.rsp_timeout, b0.rsp_overflow, b0.rsp_op}, {3'b100, 3'b110});
      chk("ill_res", b0.rsp_result, '0);
      tick();
    end
    chk("ill_nostart", 200'(starts), 200'd0);
    handshake();
    chk("ill_idle", {busy0, b0.rsp_valid, b0.cmd_ready}, 3'b001);
    // reset in the third DWAIT cycle
    send(OP_DET, ident, '0, 8'h00);
    tick();
    tick();
    tick();
    chk("rw_dwait", {busy0, b0.rsp_valid}, 2'b10);
    rst = 1'b1;
    tick();
    chk("rw_reset", {busy0, b0.rsp_valid, busy1, b1.rsp_valid, b0.cmd_ready}, 5'b00000);
    rst = 1'b0;
    cp_det_done = 1'b1;
    tick();
    cp_det_done = 1'b0;
    tick();
    chk("rw_no_rsp", {busy0, b0.rsp_valid, busy1, b1.rsp_valid, b0.cmd_ready}, 5'b00001);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
